// File: rtl/data_mem_if.sv
// Request / response / write-log bundle between the MIPS core and data_mem_ctrl.
// master = core side (drives requests, consumes log), slave = memory side.
// Handshakes: req_valid/req_ready, one-cycle resp_valid pulse, log_valid/log_ready.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_pc;
  logic [31:0] log_addr;
  logic [31:0] log_data;

  modport master (
    output req_valid, req_addr, req_byteen, req_wdata, req_pc, log_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  log_valid, log_pc, log_addr, log_data
  );

  modport slave (
    input  req_valid, req_addr, req_byteen, req_wdata, req_pc, log_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output log_valid, log_pc, log_addr, log_data
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with byte-enable merge, self zero-fill and store log FIFO.
// Latency: response LATENCY cycles after accept; one request in flight when LATENCY > 1.
// Backpressure: req_ready low while clearing, busy, or when the write log is full.
module data_mem_ctrl #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          LATENCY    = 1,
  parameter int          LOG_DEPTH  = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic       i_clk,
  input logic       i_reset,
  data_mem_if.slave bus
);

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam int          LW        = $clog2(LOG_DEPTH);
  localparam logic [LW:0] LOG_FULL  = (LW + 1)'(LOG_DEPTH);
  localparam logic [1:0]  BUSY_INIT = 2'(LATENCY > 1 ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [1:0]            r_busy_cnt;
  logic [31:0]           r_mem [DEPTH];

  logic                  r_pipe_vld   [LATENCY];
  logic                  r_pipe_err   [LATENCY];
  logic [31:0]           r_pipe_rdata [LATENCY];

  logic [31:0]           r_log_pc   [LOG_DEPTH];
  logic [31:0]           r_log_addr [LOG_DEPTH];
  logic [31:0]           r_log_data [LOG_DEPTH];
  logic [LW-1:0]         r_log_wr;
  logic [LW-1:0]         r_log_rd;
  logic [LW:0]           r_log_cnt;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_is_write;
  logic                  w_borrow;
  logic [29:0]           w_off_word;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_index;
  logic [31:0]           w_old;
  logic [31:0]           w_merged;
  logic                  w_commit;
  logic                  w_pop;

  // Ready depends only on registered state so it never loops back through req_valid.
  assign w_ready    = (r_state == S_IDLE) && (r_log_cnt < LOG_FULL);
  assign w_accept   = bus.req_valid && w_ready;
  assign w_is_write = (bus.req_byteen != 4'h0);

  // Word offset of (req_addr - BASE_ADDR), with the borrow out of the byte bits kept
  // so a misaligned base still produces the exact 32-bit wrapped difference.
  assign w_borrow   = (bus.req_addr[1:0] < BASE_ADDR[1:0]);
  assign w_off_word = bus.req_addr[31:2] - BASE_ADDR[31:2] - {29'd0, w_borrow};
  assign w_in_range = (w_off_word[29:ADDR_WIDTH] == '0);
  assign w_index    = w_off_word[ADDR_WIDTH-1:0];
  assign w_old      = r_mem[w_index];
  assign w_commit   = w_accept && w_in_range && w_is_write;
  assign w_pop      = bus.log_valid && bus.log_ready;

  // Replace only the enabled byte lanes of the stored word.
  always_comb begin
    w_merged = w_old;
    for (int b = 0; b < 4; b++) begin
      if (bus.req_byteen[b]) w_merged[8*b +: 8] = bus.req_wdata[8*b +: 8];
    end
  end

  // Control FSM: zero-fill sweep, then idle, with a busy hold for multi-cycle latency.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_CLEAR;
      r_clr_cnt  <= '0;
      r_busy_cnt <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == '1) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_accept && (LATENCY > 1)) begin
            r_state    <= S_BUSY;
            r_busy_cnt <= BUSY_INIT;
          end
        end
        S_BUSY: begin
          if (r_busy_cnt == 2'd0) r_state <= S_IDLE;
          else                    r_busy_cnt <= r_busy_cnt - 1'b1;
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Storage array: cleared word by word during CLEAR, merged word stored on a committed write.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (r_state == S_CLEAR) r_mem[r_clr_cnt] <= '0;
      else if (w_commit)      r_mem[w_index]   <= w_merged;
    end
  end

  // Response delay line; stage 0 captures at the accept edge, the last stage drives the port.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_pipe_vld[k]   <= 1'b0;
        r_pipe_err[k]   <= 1'b0;
        r_pipe_rdata[k] <= '0;
      end
    end else begin
      r_pipe_vld[0]   <= w_accept;
      r_pipe_err[0]   <= w_accept && !w_in_range;
      r_pipe_rdata[0] <= (w_accept && w_in_range && !w_is_write) ? w_old : 32'h0;
      for (int k = 1; k < LATENCY; k++) begin
        r_pipe_vld[k]   <= r_pipe_vld[k-1];
        r_pipe_err[k]   <= r_pipe_err[k-1];
        r_pipe_rdata[k] <= r_pipe_rdata[k-1];
      end
    end
  end

  // Write-log FIFO; overflow is impossible because w_ready already excludes a full log.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_log_wr  <= '0;
      r_log_rd  <= '0;
      r_log_cnt <= '0;
      for (int e = 0; e < LOG_DEPTH; e++) begin
        r_log_pc[e]   <= '0;
        r_log_addr[e] <= '0;
        r_log_data[e] <= '0;
      end
    end else begin
      if (w_commit) begin
        r_log_pc[r_log_wr]   <= bus.req_pc;
        r_log_addr[r_log_wr] <= {bus.req_addr[31:2], 2'b00};
        r_log_data[r_log_wr] <= w_merged;
        r_log_wr             <= r_log_wr + 1'b1;
      end
      if (w_pop) r_log_rd <= r_log_rd + 1'b1;
      if (w_commit && !w_pop)      r_log_cnt <= r_log_cnt + 1'b1;
      else if (!w_commit && w_pop) r_log_cnt <= r_log_cnt - 1'b1;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = r_pipe_vld[LATENCY-1];
  assign bus.resp_err   = r_pipe_err[LATENCY-1];
  assign bus.resp_rdata = r_pipe_rdata[LATENCY-1];
  assign bus.log_valid  = (r_log_cnt != '0);
  assign bus.log_pc     = r_log_pc[r_log_rd];
  assign bus.log_addr   = r_log_addr[r_log_rd];
  assign bus.log_data   = r_log_data[r_log_rd];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: three instances (latency 1, latency 3 with
// base 0x1000, latency 2 for reset-while-busy). Expected responses and log entries
// are queued at issue time and popped by independent monitors.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  data_mem_if ifa ();
  data_mem_if ifb ();
  data_mem_if ifc ();

  data_mem_ctrl #(.ADDR_WIDTH(4), .LATENCY(1), .LOG_DEPTH(4), .BASE_ADDR(32'h0000_0000))
    u_a (.i_clk(clk), .i_reset(rst_a), .bus(ifa.slave));
  data_mem_ctrl #(.ADDR_WIDTH(4), .LATENCY(3), .LOG_DEPTH(4), .BASE_ADDR(32'h0000_1000))
    u_b (.i_clk(clk), .i_reset(rst_b), .bus(ifb.slave));
  data_mem_ctrl #(.ADDR_WIDTH(4), .LATENCY(2), .LOG_DEPTH(4), .BASE_ADDR(32'h0000_0000))
    u_c (.i_clk(clk), .i_reset(rst_c), .bus(ifc.slave));

  typedef struct { logic [31:0] rdata; logic err; int due; } resp_t;
  typedef struct { logic [31:0] pc; logic [31:0] addr; logic [31:0] data; } log_t;

  resp_t qa[$], qb[$];
  log_t  la[$], lb[$];
  int checks = 0, errors = 0, cyc = 0, c_resp_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0:       return ifa.req_ready === 1'b1;
      1:       return ifb.req_ready === 1'b1;
      default: return ifc.req_ready === 1'b1;
    endcase
  endfunction

  task automatic drive(input int d, input logic v, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] pc);
    case (d)
      0: begin ifa.req_valid = v; ifa.req_addr = addr; ifa.req_byteen = be; ifa.req_wdata = wd; ifa.req_pc = pc; end
      1: begin ifb.req_valid = v; ifb.req_addr = addr; ifb.req_byteen = be; ifb.req_wdata = wd; ifb.req_pc = pc; end
      default: begin ifc.req_valid = v; ifc.req_addr = addr; ifc.req_byteen = be; ifc.req_wdata = wd; ifc.req_pc = pc; end
    endcase
  endtask

  // Called and returning on a falling edge; holds the request until accepted.
  task automatic issue(input int d, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [31:0] exp_rdata, input logic exp_err,
                       input logic exp_log, input logic [31:0] exp_log_data, output int acc);
    resp_t r;
    log_t  l;
    int    n;
    n = 0;
    drive(d, 1'b1, addr, be, wd, pc);
    while (!rdy(d) && n < 200) begin @(negedge clk); n++; end
    if (!rdy(d)) begin
      checks++; errors++;
      $display("FAIL issue_timeout: dev %0d addr %h never accepted", d, addr);
      acc = -1;
      drive(d, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
      return;
    end
    acc     = cyc + 1;
    r.rdata = exp_rdata;
    r.err   = exp_err;
    r.due   = acc + ((d == 0) ? 1 : 3) - 1;
    l.pc    = pc;
    l.addr  = {addr[31:2], 2'b00};
    l.data  = exp_log_data;
    if (d == 0) begin qa.push_back(r); if (exp_log) la.push_back(l); end
    else        begin qb.push_back(r); if (exp_log) lb.push_back(l); end
    @(negedge clk);
    drive(d, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic count_ready_low(input int d, output int n);
    n = 0;
    while (!rdy(d) && n < 100) begin n++; @(negedge clk); end
  endtask

  // Monitor A: responses and log pops, sampled just after the falling edge.
  always begin : mon_a
    resp_t r;
    log_t  l;
    @(negedge clk); #1;
    if (ifa.resp_valid === 1'b1) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_resp_unexpected: got rdata %h err %b expected no response", ifa.resp_rdata, ifa.resp_err);
      end else begin
        r = qa.pop_front();
        chk("a_rdata", ifa.resp_rdata, r.rdata);
        chk("a_err", {31'd0, ifa.resp_err}, {31'd0, r.err});
        chk("a_resp_cycle", 32'(cyc), 32'(r.due));
      end
    end
    if (ifa.log_valid === 1'b1 && ifa.log_ready === 1'b1) begin
      if (la.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_log_unexpected: got addr %h data %h expected no entry", ifa.log_addr, ifa.log_data);
      end else begin
        l = la.pop_front();
        chk("a_log_pc", ifa.log_pc, l.pc);
        chk("a_log_addr", ifa.log_addr, l.addr);
        chk("a_log_data", ifa.log_data, l.data);
      end
    end
  end

  // Monitor B.
  always begin : mon_b
    resp_t r;
    log_t  l;
    @(negedge clk); #1;
    if (ifb.resp_valid === 1'b1) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_resp_unexpected: got rdata %h err %b expected no response", ifb.resp_rdata, ifb.resp_err);
      end else begin
        r = qb.pop_front();
        chk("b_rdata", ifb.resp_rdata, r.rdata);
        chk("b_err", {31'd0, ifb.resp_err}, {31'd0, r.err});
        chk("b_resp_cycle", 32'(cyc), 32'(r.due));
      end
    end
    if (ifb.log_valid === 1'b1 && ifb.log_ready === 1'b1) begin
      if (lb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_log_unexpected: got addr %h data %h expected no entry", ifb.log_addr, ifb.log_data);
      end else begin
        l = lb.pop_front();
        chk("b_log_pc", ifb.log_pc, l.pc);
        chk("b_log_addr", ifb.log_addr, l.addr);
        chk("b_log_data", ifb.log_data, l.data);
      end
    end
  end

  // Monitor C only counts responses; none may ever appear.
  always begin : mon_c
    @(negedge clk); #1;
    if (ifc.resp_valid === 1'b1) c_resp_seen++;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, acc, acc1, acc2, acc3, p_edge;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    drive(0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    drive(2, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    ifa.log_ready = 1'b1; ifb.log_ready = 1'b1; ifc.log_ready = 1'b1;
    p_edge = 0;
    repeat (3) @(negedge clk);

    // Reset values of instance A.
    chk("a_rst_ready", {31'd0, ifa.req_ready}, 32'd0);
    chk("a_rst_resp_valid", {31'd0, ifa.resp_valid}, 32'd0);
    chk("a_rst_resp_rdata", ifa.resp_rdata, 32'd0);
    chk("a_rst_resp_err", {31'd0, ifa.resp_err}, 32'd0);
    chk("a_rst_log_valid", {31'd0, ifa.log_valid}, 32'd0);
    chk("a_rst_log_pc", ifa.log_pc, 32'd0);
    chk("a_rst_log_addr", ifa.log_addr, 32'd0);
    chk("a_rst_log_data", ifa.log_data, 32'd0);

    // Zero-fill sweep holds req_ready low for exactly 16 cycles.
    rst_a = 1'b0;
    count_ready_low(0, n);
    chk("a_clear_cycles", 32'(n), 32'd16);

    // Every word reads back zero.
    for (int i = 0; i < 16; i++) issue(0, 32'(i * 4), 4'h0, 32'h0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, acc);

    // Byte-enable merge and read-after-write on consecutive edges.
    issue(0, 32'h8,  4'hF,    32'h1122_3344, 32'h400, 32'h0, 1'b0, 1'b1, 32'h1122_3344, acc);
    issue(0, 32'hA,  4'b0100, 32'h00AA_0000, 32'h404, 32'h0, 1'b0, 1'b1, 32'h11AA_3344, acc);
    issue(0, 32'h8,  4'h0,    32'h0,         32'h408, 32'h11AA_3344, 1'b0, 1'b0, 32'h0, acc);
    issue(0, 32'h3C, 4'b0001, 32'h1234_56EE, 32'h40C, 32'h0, 1'b0, 1'b1, 32'h0000_00EE, acc);
    issue(0, 32'h3F, 4'h0,    32'h0,         32'h410, 32'h0000_00EE, 1'b0, 1'b0, 32'h0, acc);
    issue(0, 32'h0,  4'b1000, 32'h9988_7766, 32'h414, 32'h0, 1'b0, 1'b1, 32'h9900_0000, acc);
    issue(0, 32'h0,  4'h0,    32'h0,         32'h418, 32'h9900_0000, 1'b0, 1'b0, 32'h0, acc);

    // Out-of-range requests: error response, no log, memory untouched.
    issue(0, 32'h40,        4'h0, 32'h0,         32'h41C, 32'h0, 1'b1, 1'b0, 32'h0, acc);
    issue(0, 32'h44,        4'hF, 32'hFFFF_FFFF, 32'h420, 32'h0, 1'b1, 1'b0, 32'h0, acc);
    issue(0, 32'hFFFF_FFFC, 4'hF, 32'hFFFF_FFFF, 32'h424, 32'h0, 1'b1, 1'b0, 32'h0, acc);
    issue(0, 32'h4,         4'h0, 32'h0,         32'h428, 32'h0, 1'b0, 1'b0, 32'h0, acc);
    issue(0, 32'h3C,        4'h0, 32'h0,         32'h42C, 32'h0000_00EE, 1'b0, 1'b0, 32'h0, acc);
    repeat (4) @(negedge clk);

    // Log backpressure: four writes fill the log, the fifth waits for a single pop.
    ifa.log_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(0, 32'h10 + 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i), 32'h500 + 32'(i * 4),
            32'h0, 1'b0, 1'b1, 32'hA000_0000 + 32'(i), acc);
    chk("a_ready_log_full", {31'd0, ifa.req_ready}, 32'd0);
    chk("a_log_valid_full", {31'd0, ifa.log_valid}, 32'd1);
    fork
      issue(0, 32'h20, 4'hF, 32'hA000_0004, 32'h510, 32'h0, 1'b0, 1'b1, 32'hA000_0004, acc);
      begin
        repeat (2) @(negedge clk);
        ifa.log_ready = 1'b1;
        p_edge = cyc + 1;
        @(negedge clk);
        ifa.log_ready = 1'b0;
      end
    join
    chk("a_fifth_accept_edge", 32'(acc), 32'(p_edge + 1));
    ifa.log_ready = 1'b1;
    repeat (10) @(negedge clk);

    // Instance B: latency 3, base 0x1000.
    rst_b = 1'b0;
    count_ready_low(1, n);
    chk("b_clear_cycles", 32'(n), 32'd16);
    issue(1, 32'h1000, 4'h0, 32'h0, 32'h600, 32'h0, 1'b0, 1'b0, 32'h0, acc1);
    issue(1, 32'h1004, 4'h0, 32'h0, 32'h604, 32'h0, 1'b0, 1'b0, 32'h0, acc2);
    issue(1, 32'h1008, 4'h0, 32'h0, 32'h608, 32'h0, 1'b0, 1'b0, 32'h0, acc3);
    chk("b_accept_spacing_1", 32'(acc2 - acc1), 32'd3);
    chk("b_accept_spacing_2", 32'(acc3 - acc2), 32'd3);
    issue(1, 32'h103C, 4'hF,    32'hCAFE_F00D, 32'h60C, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, acc);
    issue(1, 32'h0FFC, 4'hF,    32'h5555_5555, 32'h610, 32'h0, 1'b1, 1'b0, 32'h0, acc);
    issue(1, 32'h1040, 4'h0,    32'h0,         32'h614, 32'h0, 1'b1, 1'b0, 32'h0, acc);
    issue(1, 32'h103C, 4'h0,    32'h0,         32'h618, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, acc);
    issue(1, 32'h1002, 4'b0011, 32'h0000_BEEF, 32'h61C, 32'h0, 1'b0, 1'b1, 32'h0000_BEEF, acc);
    issue(1, 32'h1000, 4'h0,    32'h0,         32'h620, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0, acc);
    repeat (8) @(negedge clk);

    // Instance C: reset the cycle after a read accept cancels the response and restarts CLEAR.
    rst_c = 1'b0;
    count_ready_low(2, n);
    chk("c_clear_cycles", 32'(n), 32'd16);
    c_resp_seen = 0;
    drive(2, 1'b1, 32'h4, 4'h0, 32'h0, 32'h700);
    chk("c_ready_before_read", {31'd0, ifc.req_ready}, 32'd1);
    @(negedge clk);
    drive(2, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    rst_c = 1'b1;
    repeat (2) @(negedge clk);
    chk("c_rst_ready", {31'd0, ifc.req_ready}, 32'd0);
    chk("c_rst_log_valid", {31'd0, ifc.log_valid}, 32'd0);
    rst_c = 1'b0;
    count_ready_low(2, n);
    chk("c_reclear_cycles", 32'(n), 32'd16);
    repeat (4) @(negedge clk);
    chk("c_no_response", 32'(c_resp_seen), 32'd0);
    chk("c_log_empty", {31'd0, ifc.log_valid}, 32'd0);

    // Every queued expectation must have been consumed.
    chk("a_resp_queue_empty", 32'(qa.size()), 32'd0);
    chk("a_log_queue_empty", 32'(la.size()), 32'd0);
    chk("b_resp_queue_empty", 32'(qb.size()), 32'd0);
    chk("b_log_queue_empty", 32'(lb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, synthesizable data memory for the pipelined MIPS core, replacing the behavioural byte-enable RAM model. It accepts word-addressed read/write requests over a valid/ready handshake with configurable read latency and merges byte-enabled writes into stored words. It zero-fills itself after reset and pushes every committed store into a back-pressured write-log FIFO for trace output.

## Interface
- ADDR_WIDTH, 12, word-index bits; depth = 2^ADDR_WIDTH words
- LATENCY, 1, response latency in cycles, legal 1..4
- LOG_DEPTH, 4, write-log FIFO entries, power of 2, ≥2
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted at edge when req_valid && req_ready
- req_addr  in  32  byte address; bits [1:0] ignored
- req_byteen  in  4  0 = read; nonzero = write of the selected bytes (bit i ↔ bits 8i+7:8i)
- req_wdata  in  32  write data, lane-aligned
- req_pc  in  32  instruction address, carried into the log
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  read word; 0 for writes and errors
- resp_err  out  1  address out of range
- log_valid  out  1  FIFO head valid
- log_ready  in  1  head consumed at edge when log_valid && log_ready
- log_pc  out  32  PC of the store
- log_addr  out  32  word-aligned byte address
- log_data  out  32  full merged word written

## Operation
- States: CLEAR, IDLE, BUSY.
- CLEAR: counter writes 0 to word[counter] each cycle; after word 2^ADDR_WIDTH−1 is written, go to IDLE. req_ready = 0 in CLEAR.
- Offset = req_addr − BASE_ADDR (32-bit unsigned, wraps). In range iff offset < 4·2^ADDR_WIDTH. Index = offset[ADDR_WIDTH+1:2].
- req_ready = (state==IDLE) && (log_count < LOG_DEPTH), using registered values only. Never depends on req_valid.
- Accepted read: sample word[index] at the accept edge. Response: resp_rdata = word, resp_err = 0.
- Accepted write: merged = old word with each enabled byte replaced. Store merged at the accept edge. Push {req_pc, aligned addr, merged} into the log in the same edge. Response: rdata 0, err 0.
- Out of range, read or write: no memory change and no log push. Response: rdata 0, err 1.
- Every accepted request yields exactly one response, in order.
- LATENCY = 1: stay IDLE, so one request per cycle.
- LATENCY > 1: go to BUSY for LATENCY−1 cycles, then return to IDLE in the response cycle.
- Log FIFO: log_valid = (count ≠ 0). Head fields stay stable while log_valid && !log_ready. Push and pop in the same edge leave count unchanged. Overflow cannot occur because of the req_ready gating.

## Timing
- Reset high at an edge: state = CLEAR, counter = 0, log FIFO emptied (count 0, storage 0), in-flight response cancelled.
- Outputs after reset: req_ready 0, resp_valid 0, resp_rdata 0, resp_err 0, log_valid 0, log_pc/addr/data 0.
- Reset held for several cycles: remain at counter 0. CLEAR starts on the first edge with reset low.
- First req_ready = 1 occurs 2^ADDR_WIDTH cycles after reset deasserts.
- Reset asserted mid-CLEAR or mid-BUSY: restart CLEAR; the pending response is never emitted.
- Request accepted at edge N: resp_valid is high during the cycle after edge N+LATENCY−1, for exactly one cycle.
- Read-after-write to the same word, accepted on consecutive edges, returns the merged word.
- Log full (count = LOG_DEPTH) with log_ready = 1: the pop occurs at that edge; req_ready rises the following cycle.

## Test plan
- ADDR_WIDTH=4, LATENCY=1: release reset → req_ready low for exactly 16 cycles. Then read every word → all rdata 0, err 0.
- Write 0x11223344 (byteen 4'hF) at 0x8, then byteen 4'b0100 data 0x00AA0000 at 0xA → log entries (0x8, 0x11223344) and (0x8, 0x11AA3344). Read of 0x8 returns 0x11AA3344.
- LATENCY=3: back-to-back reads with req_valid held → responses 3 cycles after each accept, one every 3 cycles. req_ready low for 2 cycles after each accept.
- log_ready = 0: five writes with LOG_DEPTH=4 → 4 accepted, req_ready drops. Raise log_ready for 1 cycle → fifth write accepted next cycle; drain order equals issue order.
- BASE_ADDR=0x1000: write to 0x0FFC and read of 0x1040 (ADDR_WIDTH=4) → resp_err 1, rdata 0, no log entry, memory unchanged.
- LATENCY=2: assert reset the cycle after a read accept → no resp_valid; full CLEAR repeats; FIFO empty.
